// File: rtl/fb_read_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fb_read_responder_pkg
// Brief    : Grant-state encoding and default bus widths shared with HDMI TX
//            and the processor.
// Revision : 1.0 - initial release
// ============================================================================
package fb_read_responder_pkg;

    localparam int c_addr_w = 18;
    localparam int c_data_w = 8;

    typedef logic [1:0] gnt_state_t;

    localparam gnt_state_t GNT_NONE = 2'd0;
    localparam gnt_state_t GNT_VID  = 2'd1;
    localparam gnt_state_t GNT_CPU  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/fb_read_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : fb_read_responder_if
// Brief    : Video request/response, CPU read and framebuffer RAM signals.
// Revision : 1.0 - initial release
// ============================================================================
interface fb_read_responder_if #(
    parameter int ADDR_W = fb_read_responder_pkg::c_addr_w,
    parameter int DATA_W = fb_read_responder_pkg::c_data_w
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic              cpu_rd;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_done;
    logic [DATA_W-1:0] cpu_data;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_q;
    logic              oob_err;

    modport slave (
        input  req_valid, req_addr, resp_ready, cpu_rd, cpu_addr, mem_q,
        output req_ready, resp_valid, resp_data, cpu_done, cpu_data, mem_addr, oob_err
    );

    modport master (
        output req_valid, req_addr, resp_ready, cpu_rd, cpu_addr, mem_q,
        input  req_ready, resp_valid, resp_data, cpu_done, cpu_data, mem_addr, oob_err
    );
endinterface
`default_nettype wire

// File: rtl/fb_read_responder_resp_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fb_read_responder_resp_fifo
// Brief    : Synchronous response FIFO with occupancy count and full/empty.
// Revision : 1.0 - initial release
// ============================================================================
module fb_read_responder_resp_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       i_push,
    input  wire logic [DATA_W-1:0]          i_data,
    input  wire logic                       i_pop,
    output logic      [DATA_W-1:0]          o_data,
    output logic      [$clog2(DEPTH+1)-1:0] o_count,
    output logic                            o_full,
    output logic                            o_empty
);
    localparam int              c_pw    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              c_cw    = $clog2(DEPTH + 1);
    localparam logic [c_pw-1:0] c_last  = c_pw'(DEPTH - 1);
    localparam logic [c_cw-1:0] c_depth = c_cw'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [c_pw-1:0]   r_wr_ptr;
    logic [c_pw-1:0]   r_rd_ptr;
    logic [c_cw-1:0]   r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full    = (r_count == c_depth);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    // Head is forced to zero when empty so the output has a defined reset value
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == c_last) ? '0 : r_wr_ptr + c_pw'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_last) ? '0 : r_rd_ptr + c_pw'(1);
            end
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_cw'(1);
                2'b01:   r_count <= r_count - c_cw'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fb_read_responder.sv
`default_nettype none
// ============================================================================
// Module   : fb_read_responder
// Brief    : Arbitrates video and CPU reads onto one framebuffer RAM port.
// Revision : 1.0 - initial release
// ============================================================================
module fb_read_responder
    import fb_read_responder_pkg::*;
#(
    parameter int ADDR_W     = c_addr_w,
    parameter int DATA_W     = c_data_w,
    parameter int FB_DEPTH   = 76800,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 8
) (
    input wire logic           clk,
    input wire logic           rst,
    fb_read_responder_if.slave bus
);
    localparam int              c_cw         = $clog2(FIFO_DEPTH + 1);
    localparam int              c_sw         = $clog2(STARVE_MAX + 1);
    localparam logic [ADDR_W:0] c_fb_lim     = (ADDR_W + 1)'(FB_DEPTH);
    localparam logic [c_sw-1:0] c_starve_max = c_sw'(STARVE_MAX);
    localparam logic [c_cw:0]   c_fifo_depth = (c_cw + 1)'(FIFO_DEPTH);

    gnt_state_t        r_gnt;
    gnt_state_t        w_gnt_nxt;
    logic [c_sw-1:0]   r_starve;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [ADDR_W-1:0] w_mem_addr;
    logic              r_oob_inflight;
    logic              r_oob_err;
    logic [DATA_W-1:0] r_cpu_data;
    logic [DATA_W-1:0] w_rdata;
    logic [DATA_W-1:0] w_resp_data;
    logic [c_cw-1:0]   w_fifo_count;
    logic [c_cw:0]     w_occ;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_vid_inflight;
    logic              w_cpu_inflight;
    logic              w_cpu_pend;
    logic              w_starved;
    logic              w_space;
    logic              w_req_ready;
    logic              w_vid_gnt;
    logic              w_cpu_gnt;
    logic              w_any_gnt;
    logic              w_gnt_oob;
    logic              w_cpu_done;

    assign w_vid_inflight = (r_gnt == GNT_VID);
    assign w_cpu_inflight = (r_gnt == GNT_CPU);
    assign w_cpu_pend     = bus.cpu_rd && !w_cpu_inflight;
    assign w_starved      = w_cpu_pend && (r_starve == c_starve_max);

    // Space counts the read already on the RAM port so the FIFO can never overflow
    assign w_occ       = {1'b0, w_fifo_count} + {{c_cw{1'b0}}, w_vid_inflight};
    assign w_space     = !w_fifo_full && (w_occ < c_fifo_depth);
    // A starved CPU takes the port, so video must not see a completed handshake
    assign w_req_ready = rst && w_space && !w_starved;
    assign w_vid_gnt   = bus.req_valid && w_req_ready;
    assign w_cpu_gnt   = rst && w_cpu_pend && !w_vid_gnt;
    assign w_any_gnt   = w_vid_gnt || w_cpu_gnt;
    assign w_gnt_oob   = ({1'b0, w_mem_addr} >= c_fb_lim);

    assign w_rdata = r_oob_inflight ? '0 : bus.mem_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_gnt <= GNT_NONE;
        end else begin
            r_gnt <= w_gnt_nxt;
        end
    end

    always_comb begin
        w_gnt_nxt = GNT_NONE;
        if (w_vid_gnt) begin
            w_gnt_nxt = GNT_VID;
        end else if (w_cpu_gnt) begin
            w_gnt_nxt = GNT_CPU;
        end
    end

    always_comb begin
        w_mem_addr = r_mem_addr;
        w_push     = 1'b0;
        w_cpu_done = 1'b0;
        if (w_vid_gnt) begin
            w_mem_addr = bus.req_addr;
        end else if (w_cpu_gnt) begin
            w_mem_addr = bus.cpu_addr;
        end
        // Completions are suppressed while reset is asserted so aborted reads never surface
        unique case (r_gnt)
            GNT_VID: w_push     = rst;
            GNT_CPU: w_cpu_done = rst;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_starve       <= '0;
            r_mem_addr     <= '0;
            r_oob_inflight <= 1'b0;
            r_oob_err      <= 1'b0;
            r_cpu_data     <= '0;
        end else begin
            r_mem_addr     <= w_mem_addr;
            r_oob_inflight <= w_any_gnt && w_gnt_oob;
            if (w_any_gnt && w_gnt_oob) begin
                r_oob_err <= 1'b1;
            end
            if (w_cpu_done) begin
                r_cpu_data <= w_rdata;
            end
            if (!bus.cpu_rd || w_cpu_gnt) begin
                r_starve <= '0;
            end else if (w_vid_gnt && w_cpu_pend && (r_starve != c_starve_max)) begin
                r_starve <= r_starve + c_sw'(1);
            end
        end
    end

    fb_read_responder_resp_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_resp_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_rdata),
        .i_pop   (w_pop),
        .o_data  (w_resp_data),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign w_pop = !w_fifo_empty && bus.resp_ready;

    assign bus.req_ready  = w_req_ready;
    assign bus.resp_valid = !w_fifo_empty;
    assign bus.resp_data  = w_resp_data;
    assign bus.cpu_done   = w_cpu_done;
    assign bus.cpu_data   = w_cpu_done ? w_rdata : r_cpu_data;
    assign bus.mem_addr   = w_mem_addr;
    assign bus.oob_err    = r_oob_err;

endmodule
`default_nettype wire

// File: tb/tb_fb_read_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_fb_read_responder
// Brief    : Directed self-checking bench for fb_read_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fb_read_responder;
    localparam int ADDR_W = 18;
    localparam int DATA_W = 8;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    logic [DATA_W-1:0] got_q [$];
    int                got_cyc [$];

    fb_read_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    fb_read_responder #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .FB_DEPTH   (76800),
        .FIFO_DEPTH (4),
        .STARVE_MAX (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // RAM contents: low address byte plus 0x10
    function automatic logic [DATA_W-1:0] mem_val(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] lo;
        lo = a[DATA_W-1:0];
        return lo + 8'h10;
    endfunction

    function automatic logic [31:0] q_at(input int i);
        if (i < got_q.size()) return 32'(got_q[i]);
        return 32'hDEAD_BEEF;
    endfunction

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) bus.mem_q <= mem_val(bus.mem_addr);
    always @(negedge clk) begin
        if (rst && bus.resp_valid && bus.resp_ready) begin
            got_q.push_back(bus.resp_data);
            got_cyc.push_back(cyc);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(input int n, input string tag);
        for (int k = 0; k < 50 && got_q.size() < n; k++) tick();
        check_val(tag, got_q.size(), n);
    endtask

    task automatic send_vid(input logic [ADDR_W-1:0] a, output logic ok);
        ok = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (bus.req_ready) ok = 1'b1;
            tick();
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic cpu_read(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d, output logic ok);
        ok = 1'b0;
        d  = '0;
        bus.cpu_rd   = 1'b1;
        bus.cpu_addr = a;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (bus.cpu_done) begin
                ok = 1'b1;
                d  = bus.cpu_data;
            end
            tick();
        end
        bus.cpu_rd = 1'b0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_val({pfx, "_req_ready"},  32'(bus.req_ready),  0);
        check_val({pfx, "_resp_valid"}, 32'(bus.resp_valid), 0);
        check_val({pfx, "_resp_data"},  32'(bus.resp_data),  0);
        check_val({pfx, "_cpu_done"},   32'(bus.cpu_done),   0);
        check_val({pfx, "_cpu_data"},   32'(bus.cpu_data),   0);
        check_val({pfx, "_mem_addr"},   32'(bus.mem_addr),   0);
        check_val({pfx, "_oob_err"},    32'(bus.oob_err),    0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic              ok;
        logic [DATA_W-1:0] d;
        int                vid_cnt;
        int                acc_cyc;
        int                idx;
        logic              seen;

        rst = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_addr   = '0;
        bus.resp_ready = 1'b0;
        bus.cpu_rd     = 1'b0;
        bus.cpu_addr   = '0;
        acc_cyc = 0;
        repeat (3) tick();
        @(negedge clk);
        check_reset_outputs("rst");
        tick();
        rst = 1'b1;
        @(negedge clk);
        check_val("rel_req_ready", 32'(bus.req_ready), 1);
        tick();

        // Four back-to-back requests, responses in order with 2-cycle latency
        bus.resp_ready = 1'b1;
        got_q.delete();
        got_cyc.delete();
        bus.req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.req_addr = 18'(i);
            @(negedge clk);
            check_val("b2b_accept", 32'(bus.req_ready), 1);
            if (i == 0) acc_cyc = cyc;
            tick();
        end
        bus.req_valid = 1'b0;
        wait_resp(4, "b2b_count");
        for (int i = 0; i < 4; i++) check_val("b2b_data", q_at(i), 32'(16 + i));
        check_val("b2b_latency", (got_cyc.size() > 0) ? 32'(got_cyc[0] - acc_cyc) : 32'hFFFF_FFFF, 2);

        // Backpressure: six offered with resp_ready low
        bus.resp_ready = 1'b0;
        got_q.delete();
        idx = 0;
        bus.req_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.req_addr = 18'(20 + idx);
            @(negedge clk);
            if (bus.req_ready) idx++;
            tick();
        end
        check_val("bp_accepted", idx, 4);
        @(negedge clk);
        check_val("bp_ready_low", 32'(bus.req_ready), 0);
        check_val("bp_resp_valid", 32'(bus.resp_valid), 1);
        check_val("bp_no_pop", got_q.size(), 0);
        tick();
        bus.resp_ready = 1'b1;
        for (int k = 0; k < 20 && idx < 6; k++) begin
            bus.req_addr = 18'(20 + idx);
            @(negedge clk);
            if (bus.req_ready) idx++;
            tick();
        end
        bus.req_valid = 1'b0;
        check_val("bp_all_accepted", idx, 6);
        wait_resp(6, "bp_count");
        for (int i = 0; i < 6; i++) check_val("bp_order", q_at(i), 32'(mem_val(18'(20 + i))));

        // Starvation: CPU wins after exactly 8 video grants
        got_q.delete();
        bus.resp_ready = 1'b1;
        bus.req_valid  = 1'b1;
        bus.req_addr   = 18'd200;
        tick();
        bus.req_addr   = 18'd201;
        tick();
        bus.cpu_rd   = 1'b1;
        bus.cpu_addr = 18'd100;
        vid_cnt = 0;
        seen    = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            bus.req_addr = 18'(210 + k);
            @(negedge clk);
            if (bus.mem_addr == 18'd100) begin
                seen = 1'b1;
                check_val("starve_vid_blocked", 32'(bus.req_ready), 0);
            end else if (bus.req_ready) begin
                vid_cnt++;
            end
            tick();
        end
        check_val("starve_cpu_granted", 32'(seen), 1);
        check_val("starve_vid_grants", vid_cnt, 8);
        @(negedge clk);
        check_val("starve_cpu_done", 32'(bus.cpu_done), 1);
        check_val("starve_cpu_data", 32'(bus.cpu_data), 32'h74);
        tick();
        bus.cpu_rd = 1'b0;
        @(negedge clk);
        check_val("starve_done_pulse", 32'(bus.cpu_done), 0);
        check_val("starve_data_hold", 32'(bus.cpu_data), 32'h74);
        tick();
        bus.req_valid = 1'b0;
        repeat (8) tick();

        // Address range boundary and sticky out-of-range flag
        got_q.delete();
        send_vid(18'd76799, ok);
        wait_resp(1, "edge_count");
        check_val("edge_last_word", q_at(0), 32'h0F);
        check_val("edge_no_oob", 32'(bus.oob_err), 0);
        got_q.delete();
        send_vid(18'd76800, ok);
        check_val("oob_req_accepted", 32'(ok), 1);
        send_vid(18'd5, ok);
        wait_resp(2, "oob_count");
        check_val("oob_data_zero", q_at(0), 0);
        check_val("oob_next_valid", q_at(1), 32'h15);
        @(negedge clk);
        check_val("oob_err_set", 32'(bus.oob_err), 1);
        tick();
        cpu_read(18'd7, d, ok);
        check_val("oob_cpu_done", 32'(ok), 1);
        check_val("oob_cpu_data", 32'(d), 32'h17);
        check_val("oob_err_sticky", 32'(bus.oob_err), 1);

        // Reset one cycle after a CPU grant
        bus.resp_ready = 1'b0;
        got_q.delete();
        send_vid(18'd30, ok);
        send_vid(18'd31, ok);
        bus.cpu_rd   = 1'b1;
        bus.cpu_addr = 18'd50;
        @(negedge clk);
        check_val("mf_cpu_grant_addr", 32'(bus.mem_addr), 50);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_val("mf_no_done", 32'(bus.cpu_done), 0);
        tick();
        bus.cpu_rd = 1'b0;
        @(negedge clk);
        check_reset_outputs("mf");
        tick();
        rst = 1'b1;
        @(negedge clk);
        check_val("mf_ready_after", 32'(bus.req_ready), 1);
        check_val("mf_done_after", 32'(bus.cpu_done), 0);
        bus.resp_ready = 1'b1;
        repeat (5) tick();
        check_val("mf_no_stale_resp", got_q.size(), 0);

        // Simultaneous push/pop at count 3 across pointer wrap
        bus.resp_ready = 1'b0;
        got_q.delete();
        for (int i = 0; i < 3; i++) send_vid(18'(40 + i), ok);
        tick();
        tick();
        for (int k = 0; k < 10; k++) begin
            bus.req_valid  = 1'b1;
            bus.req_addr   = 18'(43 + k);
            bus.resp_ready = 1'b0;
            @(negedge clk);
            check_val("pp_ready_cnt3", 32'(bus.req_ready), 1);
            tick();
            bus.req_valid  = 1'b0;
            bus.resp_ready = 1'b1;
            @(negedge clk);
            check_val("pp_full_cnt3", 32'(bus.req_ready), 0);
            tick();
        end
        bus.resp_ready = 1'b1;
        wait_resp(13, "pp_count");
        for (int i = 0; i < 13; i++) check_val("pp_order", q_at(i), 32'(mem_val(18'(40 + i))));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fb_read_responder.md
FB_READ_RESPONDER -- requirements
Module: fb_read_responder

Interface
REQ-001 Parameter ADDR_W, default 18, width of pixel address (matches HDMI offset).
REQ-002 Parameter DATA_W, default 8, width of pixel color word.
REQ-003 Parameter FB_DEPTH, default 76800, number of valid framebuffer words.
REQ-004 Parameter FIFO_DEPTH, default 4, video response FIFO entries (power of two).
REQ-005 Parameter STARVE_MAX, default 8, consecutive video grants allowed while a CPU read is pending.
REQ-006 Port clk, input, 1, single clock; all logic rising-edge.
REQ-007 Port rst, input, 1, synchronous active-low reset.
REQ-008 Ports req_valid/req_ready, input/output, 1/1, video pixel request handshake.
REQ-009 Port req_addr, input, ADDR_W, video pixel address.
REQ-010 Ports resp_valid/resp_ready, output/input, 1/1, video pixel response handshake.
REQ-011 Port resp_data, output, DATA_W, returned pixel color.
REQ-012 Ports cpu_rd/cpu_addr, input, 1/ADDR_W, processor read request, held until cpu_done.
REQ-013 Ports cpu_done/cpu_data, output, 1/DATA_W, one-cycle completion pulse and read data.
REQ-014 Ports mem_addr/mem_q, output/input, ADDR_W/DATA_W, shared framebuffer RAM read port; mem_q valid one cycle after mem_addr.
REQ-015 Port oob_err, output, 1, sticky out-of-range address flag.

Function
REQ-016 Block SHALL serve video and CPU reads over one RAM port, at most one grant per cycle.
REQ-017 Grant states SHALL be GNT_NONE, GNT_VID, GNT_CPU, registered each cycle.
REQ-018 Video SHALL win when req_valid && req_ready, unless CPU pending and starve counter == STARVE_MAX.
REQ-019 CPU SHALL be granted when cpu_rd asserted, no CPU read in flight, and video not granted.
REQ-020 Starve counter SHALL increment on each video grant while cpu_rd pending, clear on CPU grant or cpu_rd low, saturate at STARVE_MAX.
REQ-021 Granted address SHALL drive mem_addr combinationally in grant cycle; mem_addr holds last value when idle.
REQ-022 Grant at cycle N: data SHALL be captured at cycle N+1 (into FIFO for video, cpu_data for CPU).
REQ-023 cpu_done SHALL pulse exactly one cycle at N+1; cpu_data SHALL hold until next CPU completion.
REQ-024 req_ready SHALL equal (fifo_count + inflight_video) < FIFO_DEPTH.
REQ-025 Responses SHALL leave in request order; resp_valid = FIFO non-empty; pop on resp_valid && resp_ready.
REQ-026 Simultaneous push and pop SHALL leave count unchanged; full FIFO never overwritten, empty never underflows.
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 Address >= FB_DEPTH SHALL return data 0, still complete normally, and set oob_err until reset.
REQ-029 Minimum video latency SHALL be 2 cycles request-accept to resp_valid (N accept, N+1 capture, visible N+1 registered -> N+2).

Reset
REQ-030 When rst=0 at a clock edge: FIFO empty, pointers 0, in-flight cleared, state GNT_NONE, starve counter 0.
REQ-031 Reset values: req_ready 0, resp_valid 0, resp_data 0, cpu_done 0, cpu_data 0, mem_addr 0, oob_err 0.
REQ-032 Reset mid-operation SHALL discard in-flight reads; no cpu_done or response issued for them.
REQ-033 req_ready SHALL rise the first cycle after rst returns high.

Structure
REQ-034 Shared package SHALL hold grant-state enum and default ADDR_W/DATA_W constants, shared with HDMI TX and processor.
REQ-035 One sub-module SHALL be natural: resp_fifo (synchronous FIFO, count, full/empty).
REQ-036 Arbiter, starve counter, and in-flight tracking SHALL stay in the top module.

Verification
REQ-037 Video only: 4 back-to-back requests addr 0..3, mem returns 0x10..0x13, resp_ready=1 -> resp_data 0x10,0x11,0x12,0x13 in order, first resp_valid 2 cycles after first accept.
REQ-038 Backpressure: resp_ready=0, 6 requests offered -> exactly 4 accepted, req_ready=0, none lost; resp_ready=1 drains 4 in order, then 2 remaining accepted.
REQ-039 Starvation: continuous video requests plus cpu_rd addr 100 -> CPU granted after exactly 8 video grants, cpu_done one cycle later with mem value at 100.
REQ-040 Out of range: request addr 76800 -> resp_data 0, oob_err=1, stays 1 across later valid reads until rst.
REQ-041 Reset mid-flight: rst=0 one cycle after CPU grant -> no cpu_done, all outputs at reset values, req_ready=1 first cycle after release.
REQ-042 Simultaneous push/pop at FIFO count 3 for 10 cycles -> count stays 3, data order preserved across pointer wrap.
